// File: rtl/circle_pkg.sv
// circle_pkg: shared types and defaults for the walking-circle step scheduler.
// Holds the scheduler state enum, default parameter values and the period helper.
package circle_pkg;

    typedef enum logic {
        SCHED_IDLE = 1'b0,
        SCHED_RUN  = 1'b1
    } sched_state_e;

    localparam int unsigned DEF_BASE_PERIOD   = 25_000_000;
    localparam int unsigned DEF_SPEED_LEVELS  = 8;
    localparam int unsigned DEF_LAP_STEPS     = 12;
    localparam int unsigned DEF_AUTOSTOP_LAPS = 4;

    // Step period for a speed level: base halved per level, never below 1.
    function automatic int unsigned step_period(
        input int unsigned base,
        input int unsigned speed
    );
        int unsigned p;
        p = base >> speed;
        if (p == 0) begin
            p = 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/circle_step_timer.sv
// circle_step_timer: period counter with a >= compare against the live period.
// Ports: clk_i, rst_i (async, high), clear_i, enable_i, period_i, expire_o.
module circle_step_timer #(
    parameter int unsigned CNT_W = 25
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clear_i,
    input  logic           enable_i,
    input  logic [CNT_W:0] period_i,
    output logic           expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hit;

    always_comb begin
        // >= rather than == so a shortened period fires at once
        // instead of waiting for the counter to wrap.
        hit      = ({1'b0, cnt_q} >= (period_i - (CNT_W + 1)'(1)));
        expire_o = enable_i && !clear_i && hit;
        cnt_d    = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = hit ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/circle_step_scheduler.sv
// circle_step_scheduler: run/stop step pulse generator with speed levels and laps.
// In: clk_i, rst_i, start_i, stop_i, step_i, faster_i, slower_i. Out: step_o,
// lap_o, running_o, speed_o, lap_cnt_o. Macro CIRCLE_SCHED_AUTOSTOP_EN enables
// automatic stop after AUTOSTOP_LAPS laps since the last start.
module circle_step_scheduler
    import circle_pkg::*;
#(
    parameter int unsigned BASE_PERIOD   = DEF_BASE_PERIOD,
    parameter int unsigned SPEED_LEVELS  = DEF_SPEED_LEVELS,
    parameter int unsigned LAP_STEPS     = DEF_LAP_STEPS,
    parameter int unsigned AUTOSTOP_LAPS = DEF_AUTOSTOP_LAPS,
    parameter int unsigned SPEED_W       = $clog2(SPEED_LEVELS),
    parameter int unsigned CNT_W         = $clog2(BASE_PERIOD)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               step_i,
    input  logic               faster_i,
    input  logic               slower_i,
    output logic               step_o,
    output logic               lap_o,
    output logic               running_o,
    output logic [SPEED_W-1:0] speed_o,
    output logic [7:0]         lap_cnt_o
);

    localparam int unsigned POS_W = (LAP_STEPS > 1) ? $clog2(LAP_STEPS) : 1;
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(SPEED_LEVELS - 1);
    localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(LAP_STEPS - 1);

    sched_state_e       state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [7:0]         lap_cnt_q, lap_cnt_d;
    logic               step_q, step_d;
    logic               lap_q, lap_d;

    logic               timer_en;
    logic               timer_expire;
    logic               step_fire;
    logic               lap_wrap;
    logic [CNT_W:0]     period;

    assign period = (CNT_W + 1)'(step_period(BASE_PERIOD, 32'(speed_q)));

    // Stop in the same cycle as an expiry suppresses that step.
    assign timer_en = (state_q == SCHED_RUN) && !stop_i;

    circle_step_timer #(
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (!timer_en),
        .enable_i (timer_en),
        .period_i (period),
        .expire_o (timer_expire)
    );

`ifdef CIRCLE_SCHED_AUTOSTOP_EN
    logic [7:0] auto_q, auto_d;
`else
    logic unused_autostop;
    assign unused_autostop = ^AUTOSTOP_LAPS;
`endif

    always_comb begin
        state_d   = state_q;
        speed_d   = speed_q;
        pos_d     = pos_q;
        lap_cnt_d = lap_cnt_q;
        step_fire = 1'b0;

        case (state_q)
            SCHED_IDLE: begin
                step_fire = step_i;
                if (start_i && !stop_i) begin
                    state_d = SCHED_RUN;
                end
            end
            SCHED_RUN: begin
                step_fire = timer_expire;
                if (stop_i) begin
                    state_d = SCHED_IDLE;
                end
            end
            default: state_d = SCHED_IDLE;
        endcase

        // Lap position survives stop so it stays aligned with the animator.
        lap_wrap = step_fire && (pos_q == POS_LAST);
        if (step_fire) begin
            pos_d = lap_wrap ? '0 : pos_q + POS_W'(1);
        end
        if (lap_wrap) begin
            lap_cnt_d = lap_cnt_q + 8'd1;
        end

        unique case (1'b1)
            faster_i && !slower_i && (speed_q != SPEED_MAX):
                speed_d = speed_q + SPEED_W'(1);
            slower_i && !faster_i && (speed_q != '0):
                speed_d = speed_q - SPEED_W'(1);
            default: ;
        endcase

`ifdef CIRCLE_SCHED_AUTOSTOP_EN
        auto_d = auto_q;
        if (state_q == SCHED_IDLE && state_d == SCHED_RUN) begin
            auto_d = '0;
        end else if (state_q == SCHED_RUN && lap_wrap) begin
            auto_d = auto_q + 8'd1;
            // Leave RUN on the same edge that registers the final lap pulse.
            if (auto_q == 8'(AUTOSTOP_LAPS - 1)) begin
                state_d = SCHED_IDLE;
            end
        end
`endif

        step_d = step_fire;
        lap_d  = lap_wrap;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= SCHED_IDLE;
            speed_q   <= '0;
            pos_q     <= '0;
            lap_cnt_q <= '0;
            step_q    <= 1'b0;
            lap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            speed_q   <= speed_d;
            pos_q     <= pos_d;
            lap_cnt_q <= lap_cnt_d;
            step_q    <= step_d;
            lap_q     <= lap_d;
        end
    end

`ifdef CIRCLE_SCHED_AUTOSTOP_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            auto_q <= '0;
        end else begin
            auto_q <= auto_d;
        end
    end
`endif

    assign step_o    = step_q;
    assign lap_o     = lap_q;
    assign running_o = (state_q == SCHED_RUN);
    assign speed_o   = speed_q;
    assign lap_cnt_o = lap_cnt_q;

endmodule

// File: tb/tb_circle_step_scheduler.sv
// tb_circle_step_scheduler: directed scenarios plus random pulses, every cycle
// compared against a timestamp-based reference model of the scheduler.
module tb_circle_step_scheduler;

    localparam int BP = 16;
    localparam int SL = 4;
    localparam int LS = 12;
    localparam int AL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       step_in = 1'b0;
    logic       faster = 1'b0;
    logic       slower = 1'b0;
    logic       step_o;
    logic       lap_o;
    logic       running_o;
    logic [1:0] speed_o;
    logic [7:0] lap_cnt_o;

    always #5 clk = ~clk;

    circle_step_scheduler #(
        .BASE_PERIOD   (BP),
        .SPEED_LEVELS  (SL),
        .LAP_STEPS     (LS),
        .AUTOSTOP_LAPS (AL)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .stop_i    (stop),
        .step_i    (step_in),
        .faster_i  (faster),
        .slower_i  (slower),
        .step_o    (step_o),
        .lap_o     (lap_o),
        .running_o (running_o),
        .speed_o   (speed_o),
        .lap_cnt_o (lap_cnt_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: running flag, speed, timestamp of the last
    // period anchor (run entry or last step), lap position and counts.
    bit m_run;
    int m_speed;
    int m_anchor;
    int m_pos;
    int m_lapcnt;
    int m_auto;
    bit m_step;
    bit m_lap;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d",
                     tag, cyc, got, exp);
        end
    endtask

    function automatic int per(input int s);
        int p;
        p = BP >> s;
        return (p < 1) ? 1 : p;
    endfunction

    task automatic model_reset();
        m_run = 0; m_speed = 0; m_anchor = 0; m_pos = 0;
        m_lapcnt = 0; m_auto = 0; m_step = 0; m_lap = 0;
    endtask

    // Advance the model across the edge closing cycle `cyc`.
    task automatic model_edge(input bit st, input bit sp, input bit sn,
                              input bit f, input bit sl);
        bit nrun;
        int c1;
        c1 = cyc + 1;
        m_lap = 0;
        if (m_run) m_step = !sp && ((c1 - m_anchor) >= per(m_speed));
        else       m_step = sn;
        nrun = m_run ? !sp : (st && !sp);
        if (!m_run && nrun) begin
            m_anchor = c1;
            m_auto = 0;
        end
        if (m_step) begin
            m_anchor = c1;
            m_pos++;
            if (m_pos == LS) begin
                m_pos = 0;
                m_lap = 1;
                m_lapcnt = (m_lapcnt + 1) % 256;
            end
        end
`ifdef CIRCLE_SCHED_AUTOSTOP_EN
        if (m_run && m_lap) begin
            m_auto++;
            if (m_auto == AL) nrun = 0;
        end
`endif
        if (f && !sl && m_speed < SL - 1) m_speed++;
        else if (sl && !f && m_speed > 0) m_speed--;
        m_run = nrun;
    endtask

    task automatic tick(input bit st = 0, input bit sp = 0, input bit sn = 0,
                        input bit f = 0, input bit sl = 0);
        @(negedge clk);
        start = st; stop = sp; step_in = sn; faster = f; slower = sl;
        model_edge(st, sp, sn, f, sl);
        @(posedge clk);
        #1;
        cyc++;
        start = 0; stop = 0; step_in = 0; faster = 0; slower = 0;
        check("step_o", 32'(step_o), 32'(m_step));
        check("lap_o", 32'(lap_o), 32'(m_lap));
        check("running_o", 32'(running_o), 32'(m_run));
        check("speed_o", 32'(speed_o), 32'(m_speed));
        check("lap_cnt_o", 32'(lap_cnt_o), 32'(m_lapcnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        #1;
        check("rst_step", 32'(step_o), 0);
        check("rst_lap", 32'(lap_o), 0);
        check("rst_running", 32'(running_o), 0);
        check("rst_speed", 32'(speed_o), 0);
        check("rst_lapcnt", 32'(lap_cnt_o), 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Ticks idle cycles until step_o; n = ticks taken, -1 on timeout.
    task automatic wait_step(input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if (step_o) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int k;
        int cnt;
        model_reset();
        do_reset();

        // Start timing and steady spacing at speed 0.
        tick(1);
        check("run_after_start", 32'(running_o), 1);
        wait_step(40, n);
        check("first_step_delay", n + 1, 17);
        wait_step(40, n);
        check("spacing_s0", n, 16);

        // Speed levels and saturation.
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        check("speed_2", 32'(speed_o), 2);
        wait_step(40, n);
        wait_step(40, n);
        check("spacing_s2", n, 4);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 1);
        check("speed_sat_hi", 32'(speed_o), 3);
        wait_step(40, n);
        wait_step(40, n);
        check("spacing_s3", n, 2);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        check("speed_sat_lo", 32'(speed_o), 0);

        // Idle start+stop, manual step, step ignored in RUN.
        tick(0, 1);
        check("stopped", 32'(running_o), 0);
        tick(1, 1);
        check("start_stop_idle", 32'(running_o), 0);
        tick(0, 0, 1);
        check("manual_step", 32'(step_o), 1);
        tick();
        check("manual_step_once", 32'(step_o), 0);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 1);
            check("step_in_run", 32'(step_o), 0);
        end
        tick(0, 1);

        // Laps: twelve manual steps, then stop/restart mid-lap.
        do_reset();
        for (int i = 1; i <= LS; i++) begin
            tick(0, 0, 1);
            tick();
        end
        check("lap_cnt_one", 32'(lap_cnt_o), 1);
        tick(1);
        for (int i = 0; i < 5; i++) wait_step(40, n);
        tick(0, 1);
        tick(1);
        k = -1;
        for (int i = 1; i <= 10; i++) begin
            wait_step(40, n);
            if (lap_o) begin
                k = i;
                break;
            end
        end
        check("lap_after_restart", k, 7);
        tick(0, 1);

        // Reset mid-period at speed 2.
        tick(1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) tick();
        do_reset();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step_o) cnt++;
        end
        check("no_step_after_rst", cnt, 0);
        check("speed_after_rst", 32'(speed_o), 0);

        // Two laps at speed 3, then autostop or continued stepping.
        do_reset();
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
        tick(1);
        for (int i = 0; i < 2 * LS; i++) wait_step(10, n);
        check("lap_at_24", 32'(lap_o), 1);
        check("lap_cnt_two", 32'(lap_cnt_o), 2);
`ifdef CIRCLE_SCHED_AUTOSTOP_EN
        tick();
        check("autostop_run", 32'(running_o), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step_o) cnt++;
        end
        check("autostop_quiet", cnt, 0);
`else
        wait_step(10, n);
        check("continue_past_24", n, 2);
        check("still_running", 32'(running_o), 1);
`endif

        // Random pulses against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                tick($urandom_range(0, 19) == 0,
                     $urandom_range(0, 59) == 0,
                     $urandom_range(0, 14) == 0,
                     $urandom_range(0, 24) == 0,
                     $urandom_range(0, 24) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/circle_step_scheduler.md
# circle_step_scheduler

Step scheduler for the walking-circle 7-segment animation. Generates the single-cycle step pulse that drives the animator's `overflow_i` input, with a run/stop state machine, single-step, saturating speed levels and lap counting. Sits between the board button/command logic and the walking-circle animator; the animator itself is unchanged.

## Interface

**Parameters**

- `BASE_PERIOD`, default 25_000_000: step period in clocks at speed 0. At 50 MHz this is 0.5 s.
- `SPEED_LEVELS`, default 8: number of speed levels. Valid range is 2..(CNT_W+1).
- `LAP_STEPS`, default 12: steps per full lap (2 × NUM_OF_DISPLAYS).
- `AUTOSTOP_LAPS`, default 4: laps before automatic stop. Used only with the macro.
- `SPEED_W`, default `$clog2(SPEED_LEVELS)`: width of the speed level.
- `CNT_W`, default `$clog2(BASE_PERIOD)`: width of the period counter.

**Ports**

- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous reset, active-high.
- `start_i`  in  1  single-cycle pulse; IDLE → RUN.
- `stop_i`  in  1  single-cycle pulse; RUN → IDLE.
- `step_i`  in  1  single-cycle pulse; one manual step, honoured in IDLE only.
- `faster_i`  in  1  single-cycle pulse; speed +1, saturating.
- `slower_i`  in  1  single-cycle pulse; speed −1, saturating.
- `step_o`  out  1  registered single-cycle step pulse; connects to the animator's `overflow_i`.
- `lap_o`  out  1  registered pulse, coincident with the `step_o` that completes a lap.
- `running_o`  out  1  high in RUN.
- `speed_o`  out  SPEED_W  current speed level.
- `lap_cnt_o`  out  8  completed laps; wraps at 255.

## Operation

**States:** IDLE and RUN, from a 1-bit enum.

**IDLE**
- Period counter held at 0.
- `start_i` → RUN, with the counter cleared.
- `step_i` → `step_o` pulse on the next cycle.

**RUN**
- Counter increments every cycle.
- When `cnt >= period-1`: `step_o` is asserted on the next cycle and `cnt` returns to 0.
- `stop_i` → IDLE. Counter cleared, no step issued.
- `step_i` is ignored.

**Period**
- `period = BASE_PERIOD >> speed`, floored at 1.
- Comparison uses `>=`. When the speed increases mid-period and the new period is already reached, the step fires immediately on the next cycle rather than waiting for a counter wrap.

**Speed**
- Ranges 0 (slowest) to SPEED_LEVELS-1.
- `faster_i` at max: no change. `slower_i` at 0: no change.
- `faster_i` and `slower_i` in the same cycle: no change.
- Speed is retained across stop/start.

**Laps**
- A step counter runs 0..LAP_STEPS-1 and advances on every issued step, manual or timed.
- On wrap: `lap_o` is asserted together with that `step_o`, and `lap_cnt_o` increments.
- Stop does not clear the step counter, so the lap position tracks the animator position.

**Simultaneous events**
- `start_i` with `stop_i`: stop wins. Stays in IDLE, or leaves RUN.
- `start_i` while in RUN: ignored, the counter is not cleared.

**Reset**
- All state and outputs go to 0 asynchronously: IDLE, speed 0, lap count 0, step counter 0, all pulses low.
- This applies equally when reset is asserted mid-period.

## Timing

- Start edge at cycle t: `running_o` is high at t+1, and the first `step_o` is high at t+1+period.
- Subsequent steps follow every `period` cycles exactly, with no extra cycle at wrap.
- `step_i` in IDLE: `step_o` is high on the cycle after the pulse edge.
- `stop_i` at edge t: `running_o` is low at t+1. A step scheduled for t+1 is suppressed.
- `speed_o` updates on the cycle after the `faster_i`/`slower_i` edge.
- All outputs are registered. No combinational input-to-output path.

## Configuration

Macro: `CIRCLE_SCHED_AUTOSTOP_EN`.

- **Defined:**
  - A laps-since-start counter clears on entry to RUN.
  - When it reaches AUTOSTOP_LAPS, the FSM returns to IDLE on the same edge that registers the final `lap_o`. `running_o` is low in the cycle after `lap_o`.
  - A new `start_i` re-arms the counter.
- **Undefined:**
  - RUN continues until `stop_i`.
  - AUTOSTOP_LAPS is unused and no autostop counter is built.

## Structure

**Package `circle_pkg`**
- State enum: `SCHED_IDLE`, `SCHED_RUN`.
- Default constants: base period, speed levels, lap steps.

**Sub-module `circle_step_timer`**
- Contents: the period counter and the `>=` compare.
- Inputs: clear, enable, period.
- Output: expire pulse.

The FSM, speed register and lap logic stay in the top module.

## Test plan

Bench parameters: BASE_PERIOD=16, SPEED_LEVELS=4, LAP_STEPS=12.

1. Reset, then a `start_i` pulse → `running_o` high the next cycle; `step_o` at start+17, then every 16 cycles.
2. `faster_i` twice while running → `speed_o`=2 and step spacing 4. Five more `faster_i` → `speed_o`=3 and spacing 2. Each `slower_i` at 0 → stays 0.
3. `start_i` and `stop_i` in the same cycle while IDLE → stays IDLE. `step_i` → exactly one `step_o` on the next cycle. `step_i` during RUN → no extra pulse.
4. Twelve steps from reset → `lap_o` coincident with the 12th `step_o`, `lap_cnt_o`=1. Stop after 5 steps, then restart → the lap completes after 7 more.
5. `rst_i` asserted mid-period at speed 2 → all outputs 0 immediately. After release, no `step_o` until `start_i`; `speed_o`=0.
6. With `CIRCLE_SCHED_AUTOSTOP_EN` and AUTOSTOP_LAPS=2 → 24 steps, `running_o` low the cycle after the second `lap_o`. Without the macro, stepping continues past 24.
